fetch_pc: RTL and testbench
===========================

# fetch_pc

Program-counter and fetch-control stage for the picoMIPS core. Sits directly upstream of the program memory: drives its 5-bit `address` and sequences execution with increment, absolute/relative branch, stall, wait-for-input and halt. Branch and control requests come from the decoder, which sits downstream of the program memory.

## Interface
- `Psize`, 5, PC/address width
- `PLAST`, 21, last legal program address; program memory holds words 0..PLAST
- `clk` input 1 — system clock, rising edge
- `reset` input 1 — synchronous, active-high
- `stall` input 1 — hold PC this cycle; no retire
- `br_abs` input 1 — absolute branch to `br_addr`
- `br_rel` input 1 — relative branch by signed `br_addr`
- `br_addr` input Psize — absolute target, or two's-complement offset
- `wait_req` input 1 — enter WAIT; PC holds
- `go` input 1 — external release from WAIT
- `halt_req` input 1 — enter HALT
- `address` output Psize — current PC; drives program memory
- `waiting` output 1 — high in WAIT
- `halted` output 1 — high in HALT
- `err` output 1 — sticky; illegal branch target seen
- `retired` output 16 — retired-instruction count; see Configuration

## Operation
- States: RUN, WAIT, HALT. Reset → RUN, `address`=0, `err`=0, `retired`=0, `waiting`=0, `halted`=0.
- RUN priority, highest first:
  - `halt_req` → HALT, PC holds.
  - `stall` → PC holds, no retire.
  - `wait_req` → WAIT, PC holds, retire.
  - `br_abs` → PC=`br_addr`, retire.
  - `br_rel` → PC=(PC + sign-extended `br_addr`) mod 2^Psize, retire.
  - Otherwise → PC+1, retire.
- `br_abs` and `br_rel` together: absolute wins.
- Sequential increment from PLAST wraps to 0. Not an error.
- Branch target > PLAST: PC holds, `err` set, state → HALT, no retire.
- WAIT: PC holds. `go`=1 → PC+1, RUN, no additional retire. `go` is sampled only in WAIT, so a `go` in the entry cycle is ignored. In WAIT, `halt_req` → HALT and has priority over `go`.
- HALT: all inputs ignored; only `reset` exits.
- `err` clears only on reset.

## Timing
- All state updates on rising `clk`. `address` is registered and changes one cycle after the request.
- Program memory is combinational, so the instruction at `address` is valid in the same cycle.
- `waiting`/`halted` are registered decodes of state and assert in the cycle after the request.
- `reset` wins over every input in the same cycle, including mid-WAIT or mid-branch.

## Configuration
- `FETCH_PERF_EN` defined: 16-bit `retired` counter increments on every retire event and saturates at 16'hFFFF.
- `FETCH_PERF_EN` undefined: no counter logic; `retired` tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package `pico_pkg`:
  - `PSIZE`=5, `ISIZE`=15, `PLAST`=21
  - `typedef enum logic [1:0] {RUN, WAIT, HALT} fetch_state_t`
- One sub-module, `fetch_perf`: saturating retire counter, instantiated only under `FETCH_PERF_EN`.
- Next-PC computation is inline combinational logic.

## Test plan
- Reset, then 25 idle cycles → `address` 0,1,…,21,0,1,2; `err`=0. With perf enabled, `retired`=25.
- PC=3, `br_rel`=1, `br_addr`=5'b11110 (−2) → next `address`=1. PC=1, same offset → next `address`=31 > PLAST → `address` holds 1, `err`=1, `halted`=1 next cycle.
- PC=4, `br_abs`=1 and `br_rel`=1, `br_addr`=10 → `address`=10.
- PC=6, `wait_req` → `address` holds 6, `waiting`=1. `go` high 3 cycles later → `address`=7, `waiting`=0. A `go` pulse in the `wait_req` cycle alone → remains in WAIT.
- PC=9, `stall`=1 together with `br_abs`=1 to 2 → `address` holds 9, `retired` unchanged. Next cycle, `stall`=0 with the branch → `address`=2.
- HALT at PC=12, then `br_abs`/`go` toggled → `address` stays 12. `reset` pulse → `address`=0, `halted`=0, `err`=0, `retired`=0.

Source files
------------

// File: rtl/pico_pkg.sv
// rtl/pico_pkg.sv - shared picoMIPS sizes and fetch state encoding
package pico_pkg;

  localparam int PSIZE = 5;   // program counter / program memory address width
  localparam int ISIZE = 15;  // instruction word width
  localparam int PLAST = 21;  // last legal program memory address

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf.sv
// rtl/fetch_perf.sv - saturating retired-instruction counter
//
// Purpose: counts retire events for the fetch stage; sticks at 16'hFFFF.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; clears the count
//   inc    - one retire event this cycle
//   count  - current retired-instruction count
module fetch_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter and fetch sequencing for picoMIPS
//
// Purpose: drives the program memory address and sequences execution with
// increment, absolute/relative branch, stall, wait-for-go and halt.
// Optional feature macro: FETCH_PERF_EN (adds the saturating retire counter;
// without it `retired` is tied to zero and the port list is unchanged).
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-high
//   stall     - hold PC this cycle, no retire
//   br_abs    - absolute branch to br_addr (wins over br_rel)
//   br_rel    - relative branch by signed br_addr
//   br_addr   - absolute target or two's-complement offset
//   wait_req  - enter WAIT, PC holds
//   go        - release from WAIT
//   halt_req  - enter HALT
//   address   - current PC, drives program memory
//   waiting   - high in WAIT
//   halted    - high in HALT
//   err       - sticky illegal-branch-target flag
//   retired   - retired-instruction count
module fetch_pc
  import pico_pkg::*;
#(
  parameter int Psize = PSIZE,
  parameter int PLAST = pico_pkg::PLAST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_abs,
  input  logic             br_rel,
  input  logic [Psize-1:0] br_addr,
  input  logic             wait_req,
  input  logic             go,
  input  logic             halt_req,
  output logic [Psize-1:0] address,
  output logic             waiting,
  output logic             halted,
  output logic             err,
  output logic [15:0]      retired
);

  localparam logic [Psize-1:0] LAST_ADDR = Psize'(PLAST);

  fetch_state_t     state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic             waiting_q, halted_q;

  logic [Psize-1:0] pc_inc;
  logic [Psize-1:0] br_target;
  logic             br_take;
  logic             br_bad;

  // Sequential increment wraps from the last word back to 0 without error.
  assign pc_inc    = (pc_q == LAST_ADDR) ? '0 : pc_q + Psize'(1);
  assign br_take   = br_abs | br_rel;
  // Relative add is naturally modulo 2^Psize; absolute wins when both set.
  assign br_target = br_abs ? br_addr : pc_q + br_addr;
  assign br_bad    = br_take && (br_target > LAST_ADDR);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (wait_req) begin
          state_d = WAIT;
        end else if (br_take) begin
          if (br_bad) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = br_target;
          end
        end else begin
          pc_d = pc_inc;
        end
      end
      WAIT: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (go) begin
          pc_d    = pc_inc;
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      err_q     <= 1'b0;
      waiting_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      waiting_q <= (state_d == WAIT);
      halted_q  <= (state_d == HALT);
    end
  end

  assign address = pc_q;
  assign waiting = waiting_q;
  assign halted  = halted_q;
  assign err     = err_q;

`ifdef FETCH_PERF_EN
  // A RUN cycle retires unless it halts, stalls, or takes an illegal branch;
  // wait_req outranks the branch, so entering WAIT always retires.
  logic retire;
  assign retire = (state_q == RUN) && !halt_req && !stall && (wait_req || !br_bad);

  fetch_perf u_perf (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (retired)
  );
`else
  assign retired = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard testbench for fetch_pc
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_abs = 1'b0;
  logic        br_rel = 1'b0;
  logic [4:0]  br_addr = 5'd0;
  logic        wait_req = 1'b0;
  logic        go = 1'b0;
  logic        halt_req = 1'b0;
  logic [4:0]  address;
  logic        waiting;
  logic        halted;
  logic        err;
  logic [15:0] retired;

  int checks = 0;
  int failures = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic        w;
    logic        h;
    logic        e;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ret_model = 16'd0;

  fetch_pc dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .br_abs   (br_abs),
    .br_rel   (br_rel),
    .br_addr  (br_addr),
    .wait_req (wait_req),
    .go       (go),
    .halt_req (halt_req),
    .address  (address),
    .waiting  (waiting),
    .halted   (halted),
    .err      (err),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new registered state, pop one entry.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "address", {11'd0, address}, {11'd0, e.addr});
      chk(e.name, "waiting", {15'd0, waiting}, {15'd0, e.w});
      chk(e.name, "halted",  {15'd0, halted},  {15'd0, e.h});
      chk(e.name, "err",     {15'd0, err},     {15'd0, e.e});
      chk(e.name, "retired", retired, e.ret);
    end
  end

  // Drive one cycle of inputs and queue the hand-computed result.
  // ctl = {reset, stall, br_abs, br_rel, wait_req, go, halt_req}
  task automatic step(input string nm, input logic [6:0] ctl, input logic [4:0] a,
                      input logic [4:0] ea, input bit ew, input bit eh, input bit ee,
                      input bit inc);
    exp_t e;
    @(negedge clk);
    {reset, stall, br_abs, br_rel, wait_req, go, halt_req} = ctl;
    br_addr = a;
    if (ctl[6]) ret_model = 16'd0;
    else if (inc) ret_model = ret_model + 16'd1;
    e.name = nm;
    e.addr = ea;
    e.w    = ew;
    e.h    = eh;
    e.e    = ee;
    e.ret  = PERF ? ret_model : 16'd0;
    sb.push_back(e);
  endtask

  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] RST  = 7'b1000000;
  localparam logic [6:0] STL  = 7'b0100000;
  localparam logic [6:0] BA   = 7'b0010000;
  localparam logic [6:0] BR   = 7'b0001000;
  localparam logic [6:0] WR   = 7'b0000100;
  localparam logic [6:0] GO   = 7'b0000010;
  localparam logic [6:0] HR   = 7'b0000001;

  initial begin
    step("reset", RST, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int k = 1; k <= 25; k++)
      step("idle_seq", IDLE, 5'd0, 5'(k % 22), 0, 0, 0, 1);
    step("rel_m2", BR, 5'b11110, 5'd1, 0, 0, 0, 1);
    step("rel_bad", BR, 5'b11110, 5'd1, 0, 1, 1, 0);
    step("halt_ign", BA | GO, 5'd5, 5'd1, 0, 1, 1, 0);
    step("reset_err", RST, 5'd0, 5'd0, 0, 0, 0, 0);
    step("abs_bad22", BA, 5'd22, 5'd0, 0, 1, 1, 0);
    step("reset2", RST, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      step("idle_to4", IDLE, 5'd0, 5'(k), 0, 0, 0, 1);
    step("abs_rel_both", BA | BR, 5'd10, 5'd10, 0, 0, 0, 1);
    step("abs6", BA, 5'd6, 5'd6, 0, 0, 0, 1);
    step("wait_go_entry", WR | GO, 5'd0, 5'd6, 1, 0, 0, 1);
    step("wait_hold1", IDLE, 5'd0, 5'd6, 1, 0, 0, 0);
    step("wait_hold2", IDLE, 5'd0, 5'd6, 1, 0, 0, 0);
    step("wait_go", GO, 5'd0, 5'd7, 0, 0, 0, 0);
    step("abs9", BA, 5'd9, 5'd9, 0, 0, 0, 1);
    step("stall_br", STL | BA, 5'd2, 5'd9, 0, 0, 0, 0);
    step("br_after", BA, 5'd2, 5'd2, 0, 0, 0, 1);
    step("wait2", WR, 5'd0, 5'd2, 1, 0, 0, 1);
    step("wait_halt_go", HR | GO, 5'd0, 5'd2, 0, 1, 0, 0);
    step("reset3", RST, 5'd0, 5'd0, 0, 0, 0, 0);
    step("abs12", BA, 5'd12, 5'd12, 0, 0, 0, 1);
    step("halt12", HR, 5'd0, 5'd12, 0, 1, 0, 0);
    step("halt_br", BA, 5'd3, 5'd12, 0, 1, 0, 0);
    step("halt_go", GO, 5'd0, 5'd12, 0, 1, 0, 0);
    step("halt_mix", WR | BR, 5'd1, 5'd12, 0, 1, 0, 0);
    step("reset4", RST | BA | GO, 5'd7, 5'd0, 0, 0, 0, 0);
    step("abs_last", BA, 5'd21, 5'd21, 0, 0, 0, 1);
    step("wrap", IDLE, 5'd0, 5'd0, 0, 0, 0, 1);
    step("stall_hold", STL, 5'd0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    {reset, stall, br_abs, br_rel, wait_req, go, halt_req} = IDLE;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
